// File: rtl/cla_mw_add_seq_pkg.sv
// -----------------------------------------------------------------------------
// cla_mw_add_seq_pkg
// Shared definitions for the multi-word add/subtract sequencer:
//   - SLICE_W        : width of the single CLA slice (16 bits)
//   - state_e        : sequencer state encoding (IDLE/RUN/DONE)
//   - signed_ovf()   : two's-complement overflow from the three MSBs
//   - `CLA_SLICE     : selects 16-bit slice number idx out of a wide vector
// -----------------------------------------------------------------------------
`ifndef CLA_MW_ADD_SEQ_PKG_SV
`define CLA_MW_ADD_SEQ_PKG_SV

// Slice idx (LSB slice = 0) of a wide operand vector.
`define CLA_SLICE(vec, idx) vec[(idx) * cla_mw_add_seq_pkg::SLICE_W +: cla_mw_add_seq_pkg::SLICE_W]

package cla_mw_add_seq_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Overflow when both addends share a sign and the result sign differs.
   // b_msb is the MSB of the already-inverted operand for subtraction.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_msb,
                                       input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

`endif

// File: rtl/cla_mw_add_seq_cla.sv
// -----------------------------------------------------------------------------
// cla_16bits
// 16-bit carry-look-ahead adder: four 4-bit groups with group generate/
// propagate and a fully expanded look-ahead across the groups.
// Ports:
//   a_i, b_i : 16-bit addends
//   c_i      : carry in
//   s_o      : 16-bit sum
//   c_o      : carry out of bit 15
// -----------------------------------------------------------------------------
module cla_16bits
   import cla_mw_add_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic               c_i,
   output logic [SLICE_W-1:0] s_o,
   output logic               c_o
);

   logic [SLICE_W-1:0] g_s;
   logic [SLICE_W-1:0] p_s;
   logic [SLICE_W-1:0] c_s;
   logic [3:0]         gg_s;
   logic [3:0]         gp_s;
   logic [4:0]         gc_s;

   assign g_s = a_i & b_i;
   assign p_s = a_i ^ b_i;

   // Group generate / propagate for each 4-bit group.
   always_comb begin
      gg_s = 4'b0000;
      gp_s = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         gg_s[k] = g_s[4*k+3]
                 | (p_s[4*k+3] & g_s[4*k+2])
                 | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
         gp_s[k] = &p_s[4*k +: 4];
      end
   end

   // Group carries, expanded so no carry ripples between groups.
   assign gc_s[0] = c_i;
   assign gc_s[1] = gg_s[0] | (gp_s[0] & c_i);
   assign gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & c_i);
   assign gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                  | (gp_s[2] & gp_s[1] & gp_s[0] & c_i);
   assign gc_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                  | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                  | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & c_i);

   // Bit carries inside each group from that group's carry-in.
   always_comb begin
      c_s = '0;
      for (int k = 0; k < 4; k++) begin
         c_s[4*k]   = gc_s[k];
         c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
         c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                    | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
         c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                    | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
      end
   end

   assign s_o = p_s ^ c_s;
   assign c_o = gc_s[4];

endmodule

// File: rtl/cla_mw_add_seq.sv
// -----------------------------------------------------------------------------
// cla_mw_add_seq
// Multi-word add/subtract sequencer. Operands of 16*WORDS bits are accepted
// in IDLE, pushed one 16-bit slice per cycle (LSB first) through a single
// cla_16bits instance with the carry held in a register, and the full result
// is presented in DONE until the consumer takes it.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous reset, active high
//   in_valid_i   : command valid
//   in_ready_o   : command can be accepted (IDLE only)
//   a_i, b_i     : operands, sampled on the accept edge
//   sub_i        : 0 = A+B, 1 = A-B (A + ~B + 1)
//   out_valid_o  : result valid (DONE only)
//   out_ready_i  : consumer accepts result
//   sum_o        : registered full-width result
//   c_out_o      : carry out of MSB slice (1 = no borrow on subtract)
//   ovf_o        : two's-complement signed overflow
// -----------------------------------------------------------------------------
module cla_mw_add_seq
   import cla_mw_add_seq_pkg::*;
#(
   parameter int WORDS = 4
)
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [SLICE_W*WORDS-1:0] a_i,
   input  logic [SLICE_W*WORDS-1:0] b_i,
   input  logic                     sub_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [SLICE_W*WORDS-1:0] sum_o,
   output logic                     c_out_o,
   output logic                     ovf_o
);

   localparam int W     = SLICE_W * WORDS;
   localparam int IDX_W = $clog2(WORDS);

   state_e             state_q;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;       // holds ~b for subtraction
   logic [W-1:0]       sum_q;
   logic [W-1:0]       sum_d;
   logic               carry_q;
   logic [IDX_W-1:0]   idx_q;
   logic               c_out_q;
   logic               ovf_q;
   logic               in_ready_q;
   logic               out_valid_q;

   logic [SLICE_W-1:0] cla_a_s;
   logic [SLICE_W-1:0] cla_b_s;
   logic [SLICE_W-1:0] cla_s_s;
   logic               cla_c_s;

   assign cla_a_s = `CLA_SLICE(a_q, idx_q);
   assign cla_b_s = `CLA_SLICE(b_q, idx_q);

   cla_16bits u_cla (
      .a_i (cla_a_s),
      .b_i (cla_b_s),
      .c_i (carry_q),
      .s_o (cla_s_s),
      .c_o (cla_c_s)
   );

   // Per-slice write enable: only the slice addressed by idx takes the CLA sum.
   always_comb begin
      sum_d = sum_q;
      for (int w = 0; w < WORDS; w++) begin
         if ((state_q == RUN) && (idx_q == IDX_W'(w))) begin
            sum_d[w*SLICE_W +: SLICE_W] = cla_s_s;
         end else begin
            sum_d[w*SLICE_W +: SLICE_W] = sum_q[w*SLICE_W +: SLICE_W];
         end
      end
   end

   // Sequencer FSM with registered handshake and result outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         c_out_q     <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  a_q        <= a_i;
                  b_q        <= sub_i ? ~b_i : b_i;
                  carry_q    <= sub_i;    // the +1 of two's-complement negate
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end else begin
                  state_q    <= IDLE;
               end
            end
            RUN: begin
               carry_q <= cla_c_s;
               if (idx_q == IDX_W'(WORDS - 1)) begin
                  // Last slice: idx is left at WORDS-1 rather than wrapping.
                  c_out_q     <= cla_c_s;
                  ovf_q       <= signed_ovf(a_q[W-1], b_q[W-1], cla_s_s[SLICE_W-1]);
                  out_valid_o_guard: out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  idx_q       <= idx_q + IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  state_q     <= DONE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign sum_o       = sum_q;
   assign c_out_o     = c_out_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_cla_mw_add_seq.sv
module tb_cla_mw_add_seq;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         c;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;

   exp_t sb_q[$];
   exp_t last_exp;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;

   cla_mw_add_seq #(.WORDS(WORDS)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .sub_i       (sub),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .sum_o       (sum),
      .c_out_o     (c_out),
      .ovf_o       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
      exp_t e;
      e.sum = s;
      e.c   = c;
      e.ovf = o;
      return e;
   endfunction

   // Reference: plain wide arithmetic on the two's-complement operands.
   function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s);
      exp_t         e;
      logic [W:0]   t;
      logic signed [W:0] sa;
      logic signed [W:0] sb;
      logic signed [W:0] sr;
      t = s ? ({1'b0, aa} + {1'b0, ~bb} + (W+1)'(1)) : ({1'b0, aa} + {1'b0, bb});
      e.sum = t[W-1:0];
      e.c   = t[W];
      sa = {aa[W-1], aa};
      sb = {bb[W-1], bb};
      sr = s ? (sa - sb) : (sa + sb);
      e.ovf = (sr[W] != sr[W-1]);
      return e;
   endfunction

   task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s,
                       input exp_t e, input bit push, output int acc_cyc);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL send_wait in_ready=%b required 1", in_ready);
      end
      a = aa;
      b = bb;
      sub = s;
      in_valid = 1'b1;
      if (push) sb_q.push_back(e);
      @(posedge clk); #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      sub = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_result(output int edges);
      exp_t e;
      edges = 0;
      while (!out_valid && edges < 50) begin
         @(posedge clk); #1;
         edges++;
      end
      if (!out_valid) begin
         vectors++;
         miscompares++;
         $display("FAIL result_timeout out_valid=0 required 1 after %0d edges", edges);
      end else if (sb_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_result sum=%h required no result", sum);
      end else begin
         e = sb_q.pop_front();
         last_exp = e;
         vectors++;
         if (sum !== e.sum) begin
            miscompares++;
            $display("FAIL sum got %h required %h", sum, e.sum);
         end
         vectors++;
         if (c_out !== e.c) begin
            miscompares++;
            $display("FAIL c_out got %b required %b", c_out, e.c);
         end
         vectors++;
         if (ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL ovf got %b required %b", ovf, e.ovf);
         end
      end
      if (out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
      vectors++;
      if (sum !== '0) begin miscompares++; $display("FAIL reset_sum got %h required 0", sum); end
      vectors++;
      if (c_out !== 1'b0 || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags got c_out=%b ovf=%b required 0 0", c_out, ovf);
      end
   endtask

   task automatic test_slice_carry();
      int acc;
      int edges;
      send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, mk(64'h0000_0000_0001_0000, 1'b0, 1'b0), 1'b1, acc);
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL run_in_ready got %b required 0", in_ready); end
      wait_result(edges);
      // out_valid visible after WORDS edges, i.e. sampled high at edge WORDS+1
      vectors++;
      if (edges !== WORDS) begin miscompares++; $display("FAIL latency got %0d required %0d", edges, WORDS); end
   endtask

   task automatic test_full_ripple();
      int acc;
      int edges;
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, mk(64'h0, 1'b1, 1'b0), 1'b1, acc);
      wait_result(edges);
   endtask

   task automatic test_overflow();
      int acc;
      int edges;
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1), 1'b1, acc);
      wait_result(edges);
   endtask

   task automatic test_subtract();
      int acc;
      int edges;
      send(64'd5, 64'd7, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0), 1'b1, acc);
      wait_result(edges);
      send(64'd7, 64'd5, 1'b1, mk(64'd2, 1'b1, 1'b0), 1'b1, acc);
      wait_result(edges);
   endtask

   task automatic test_back_to_back();
      int acc1;
      int acc2;
      int edges;
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = 64'h1234_5678_9ABC_DEF0;
      y = 64'h0FED_CBA9_8765_4321;
      send(x, y, 1'b0, model(x, y, 1'b0), 1'b1, acc1);
      wait_result(edges);
      send(y, x, 1'b1, model(y, x, 1'b1), 1'b1, acc2);
      vectors++;
      if (acc2 - acc1 !== WORDS + 2) begin
         miscompares++;
         $display("FAIL throughput got %0d cycles required %0d", acc2 - acc1, WORDS + 2);
      end
      wait_result(edges);
   endtask

   task automatic test_backpressure();
      int acc;
      int edges;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] nx;
      logic [W-1:0] ny;
      x  = 64'h8000_0000_0000_0001;
      y  = 64'h8000_0000_0000_0002;
      nx = 64'h0000_1111_2222_3333;
      ny = 64'h0000_0000_0000_4444;
      out_ready = 1'b0;
      send(x, y, 1'b0, model(x, y, 1'b0), 1'b1, acc);
      wait_result(edges);
      a = nx;
      b = ny;
      sub = 1'b0;
      in_valid = 1'b1;
      sb_q.push_back(model(nx, ny, 1'b0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hs got out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
         end
         vectors++;
         if (sum !== last_exp.sum || c_out !== last_exp.c || ovf !== last_exp.ovf) begin
            miscompares++;
            $display("FAIL stall_hold got %h/%b/%b required %h/%b/%b",
                     sum, c_out, ovf, last_exp.sum, last_exp.c, last_exp.ovf);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL release_idle got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      vectors++;
      if (sum !== last_exp.sum) begin
         miscompares++;
         $display("FAIL idle_keeps_sum got %h required %h", sum, last_exp.sum);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL new_accept in_ready got %b required 0", in_ready);
      end
      wait_result(edges);
      vectors++;
      if (edges !== WORDS) begin miscompares++; $display("FAIL bp_latency got %0d required %0d", edges, WORDS); end
   endtask

   task automatic test_reset_midrun();
      int acc;
      int edges;
      send(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, mk(64'h0, 1'b0, 1'b0), 1'b0, acc);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midrun_rst_hs got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
      vectors++;
      if (sum !== '0 || c_out !== 1'b0) begin
         miscompares++;
         $display("FAIL midrun_rst_sum got %h/%b required 0/0", sum, c_out);
      end
      // rst together with in_valid: command must be dropped
      rst = 1'b1;
      in_valid = 1'b1;
      a = 64'd3;
      b = 64'd4;
      sub = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_vs_valid in_ready got %b required 1", in_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_vs_valid_idle got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
      send(64'd1, 64'd1, 1'b0, mk(64'd2, 1'b0, 1'b0), 1'b1, acc);
      wait_result(edges);
   endtask

   task automatic test_random();
      int acc;
      int edges;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
      for (int i = 0; i < 10; i++) begin
         x = {$urandom(), $urandom()};
         y = {$urandom(), $urandom()};
         s = 1'($urandom_range(0, 1));
         send(x, y, s, model(x, y, s), 1'b1, acc);
         wait_result(edges);
      end
   endtask

   initial begin
      test_reset();
      test_slice_carry();
      test_full_ripple();
      test_overflow();
      test_subtract();
      test_back_to_back();
      test_backpressure();
      test_reset_midrun();
      test_random();
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got %0d pending required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
